// File: rtl/wb_pkg.sv
// Writeback stage shared definitions: register/data widths, the discard register, source select.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Port summary: none; imported by wb_tag_fifo and wb_stage.
package wb_pkg;

  // R31 is the discard register: results aimed at it are consumed but never written.
  localparam logic [4:0] REG_ZERO = 5'd31;
  localparam int         REG_AW   = 5;
  localparam int         DATA_W   = 32;

  // Which source owns the register-file write port in a given cycle.
  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LD
  } wbSrc_t;

endpackage

// File: rtl/wb_tag_fifo.sv
// Load destination-tag FIFO with parallel compare of two read addresses against all pending tags.
// Latency: push/pop take effect at the next rising edge; headTag and matches are combinational.
// Backpressure: full is exported; a push while full is dropped unless a pop happens in the same cycle.
// Ports: clk/reset (sync, active high); push/pushTag; pop/headTag; full/empty;
//        matchAddr1/matchAddr2 -> match1/match2 (hit on any live entry).
module wb_tag_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [REG_AW-1:0] pushTag,
  input  logic              pop,
  output logic [REG_AW-1:0] headTag,
  output logic              full,
  output logic              empty,
  input  logic [REG_AW-1:0] matchAddr1,
  input  logic [REG_AW-1:0] matchAddr2,
  output logic              match1,
  output logic              match2
);

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = 1;
  localparam logic [PTR_W:0]   CNT_FULL  = DEPTH;
  localparam logic [PTR_W-1:0] PTR_ONE   = 1;

  logic [REG_AW-1:0] tagMem [DEPTH];
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W:0]    count;
  logic              doPush;
  logic              doPop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign headTag = tagMem[rdPtr];
  assign doPop   = pop && !empty;
  // A pop frees the head slot in the same cycle, so push+pop is legal even when full.
  assign doPush  = push && (!full || doPop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Tag storage needs no reset: liveness comes from the pointers and count only.
  always_ff @(posedge clk) begin
    if (!reset && doPush) tagMem[wrPtr] <= pushTag;
  end

  // An entry is live when its distance from the read pointer (mod DEPTH) is below count.
  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] offset;
      logic             live;
      offset = PTR_W'(i) - rdPtr;
      live   = ({1'b0, offset} < count);
      if (live && (tagMem[i] == matchAddr1)) match1 = 1'b1;
      if (live && (tagMem[i] == matchAddr2)) match2 = 1'b1;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU vs in-order load returns onto one register-file write port.
// Latency: one cycle from accepted result to WriteEnable/WriteAddr/WriteData.
// Backpressure: alu_ready drops whenever a load returns; ld_issue_ready drops when the tag FIFO is full.
// Ports: clk/reset; alu_valid/alu_ready/alu_rc/alu_data; ld_issue/ld_issue_rc/ld_issue_ready;
//        ld_valid/ld_data; rd_addr1/rd_addr2 -> hazard; ld_err (sticky); WriteEnable/WriteAddr/WriteData.
// Build option WB_BYPASS_EN: adds fwd_hit1/fwd_hit2/fwd_data so the writeback value can be forwarded
// instead of stalling operand fetch on it.
module wb_stage
  import wb_pkg::*;
#(
  parameter int LD_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rc,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_issue,
  input  logic [REG_AW-1:0] ld_issue_rc,
  output logic              ld_issue_ready,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [REG_AW-1:0] rd_addr1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic              hazard,
  output logic              ld_err,
  output logic              WriteEnable,
  output logic [REG_AW-1:0] WriteAddr,
  output logic [DATA_W-1:0] WriteData
`ifdef WB_BYPASS_EN
  ,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  logic              tagFull;
  logic              tagEmpty;
  logic [REG_AW-1:0] headTag;
  logic              tagMatch1;
  logic              tagMatch2;
  logic              ldPop;
  wbSrc_t            wbSel;
  logic [REG_AW-1:0] selAddr;
  logic [DATA_W-1:0] selData;
  logic              wrHit;
  logic              tagHaz;
  logic              wbHit1;
  logic              wbHit2;

  // A load return with nothing pending is an error: it must not pop or write.
  assign ldPop          = ld_valid && !tagEmpty;
  assign alu_ready      = !ld_valid;
  assign ld_issue_ready = !tagFull;

  wb_tag_fifo #(
    .DEPTH(LD_DEPTH)
  ) u_tagFifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ld_issue),
    .pushTag   (ld_issue_rc),
    .pop       (ldPop),
    .headTag   (headTag),
    .full      (tagFull),
    .empty     (tagEmpty),
    .matchAddr1(rd_addr1),
    .matchAddr2(rd_addr2),
    .match1    (tagMatch1),
    .match2    (tagMatch2)
  );

  always_comb begin
    wbSel   = WB_NONE;
    selAddr = alu_rc;
    selData = alu_data;
    if (ldPop) begin
      wbSel   = WB_LD;
      selAddr = headTag;
      selData = ld_data;
    end else if (alu_valid && alu_ready) begin
      wbSel = WB_ALU;
    end
    // R31 results are consumed but never reach the register file.
    wrHit = (wbSel != WB_NONE) && (selAddr != REG_ZERO);
  end

  // Address/data only move on a real write so the last written value stays visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      WriteEnable <= 1'b0;
      WriteAddr   <= '0;
      WriteData   <= '0;
      ld_err      <= 1'b0;
    end else begin
      WriteEnable <= wrHit;
      if (wrHit) begin
        WriteAddr <= selAddr;
        WriteData <= selData;
      end
      if (ld_valid && tagEmpty) ld_err <= 1'b1;
    end
  end

  assign tagHaz = ((rd_addr1 != REG_ZERO) && tagMatch1) ||
                  ((rd_addr2 != REG_ZERO) && tagMatch2);
  assign wbHit1 = WriteEnable && (WriteAddr == rd_addr1);
  assign wbHit2 = WriteEnable && (WriteAddr == rd_addr2);

`ifdef WB_BYPASS_EN
  assign hazard   = tagHaz;
  assign fwd_hit1 = wbHit1;
  assign fwd_hit2 = wbHit2;
  assign fwd_data = WriteData;
`else
  // Without forwarding, the value being written this cycle is not yet readable.
  assign hazard = tagHaz || wbHit1 || wbHit2;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rc;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rc;
  logic        ld_issue_ready;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        hazard;
  logic        ld_err;
  logic        WriteEnable;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
`ifdef WB_BYPASS_EN
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data;
`endif

  wb_stage #(.LD_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_rc        (alu_rc),
    .alu_data      (alu_data),
    .ld_issue      (ld_issue),
    .ld_issue_rc   (ld_issue_rc),
    .ld_issue_ready(ld_issue_ready),
    .ld_valid      (ld_valid),
    .ld_data       (ld_data),
    .rd_addr1      (rd_addr1),
    .rd_addr2      (rd_addr2),
    .hazard        (hazard),
    .ld_err        (ld_err),
    .WriteEnable   (WriteEnable),
    .WriteAddr     (WriteAddr),
    .WriteData     (WriteData)
`ifdef WB_BYPASS_EN
    ,
    .fwd_hit1      (fwd_hit1),
    .fwd_hit2      (fwd_hit2),
    .fwd_data      (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t expQ[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expectWr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every register-file write must match the next expected one.
  always @(negedge clk) begin
    if (WriteEnable === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=0x%0h, expected no write", WriteAddr, WriteData);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        if (WriteAddr !== e.addr || WriteData !== e.data) begin
          errors++;
          $display("FAIL write_mismatch: got addr=%0d data=0x%0h, expected addr=%0d data=0x%0h",
                   WriteAddr, WriteData, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rc = '0; alu_data = '0;
    ld_issue = 1'b0; ld_issue_rc = '0; ld_valid = 1'b0; ld_data = '0;
    rd_addr1 = '0; rd_addr2 = '0;
    repeat (2) tick;
    chk("rst_we",    WriteEnable, 0);
    chk("rst_waddr", WriteAddr, 0);
    chk("rst_wdata", WriteData, 0);
    chk("rst_lderr", ld_err, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_issue_ready", ld_issue_ready, 1);
    reset = 1'b0;

    // Plain ALU write, then idle cycle holds address/data.
    alu_valid = 1'b1; alu_rc = 5'd3; alu_data = 32'hDEADBEEF;
    #1 chk("alu_ready_idle", alu_ready, 1);
    expectWr(5'd3, 32'hDEADBEEF);
    tick;
    alu_valid = 1'b0; rd_addr1 = 5'd3;
    #1;
    chk("alu_we", WriteEnable, 1);
    chk("alu_waddr", WriteAddr, 3);
    chk("alu_wdata", WriteData, 32'hDEADBEEF);
`ifdef WB_BYPASS_EN
    chk("wb_match_hazard", hazard, 0);
    chk("fwd_hit1", fwd_hit1, 1);
    chk("fwd_hit2", fwd_hit2, 0);
    chk("fwd_data", fwd_data, 32'hDEADBEEF);
`else
    chk("wb_match_hazard", hazard, 1);
`endif
    tick;
    #1;
    chk("idle_we", WriteEnable, 0);
    chk("idle_waddr_hold", WriteAddr, 3);
    chk("idle_hazard", hazard, 0);
    rd_addr1 = '0;

    // Load return beats a simultaneous ALU result; ALU is written the next cycle.
    ld_issue = 1'b1; ld_issue_rc = 5'd7;
    tick;
    ld_issue = 1'b0; rd_addr1 = 5'd7;
    #1 chk("pending7_hazard", hazard, 1);
    rd_addr1 = '0;
    ld_valid = 1'b1; ld_data = 32'h11112222;
    alu_valid = 1'b1; alu_rc = 5'd9; alu_data = 32'h99;
    #1 chk("ld_prio_alu_ready", alu_ready, 0);
    expectWr(5'd7, 32'h11112222);
    tick;
    ld_valid = 1'b0;
    #1 chk("alu_ready_after_ld", alu_ready, 1);
    chk("ld_waddr", WriteAddr, 7);
    expectWr(5'd9, 32'h99);
    tick;
    alu_valid = 1'b0;
    #1 chk("alu_after_ld_waddr", WriteAddr, 9);

    // Fill the tag FIFO, then push+pop while full.
    for (int t = 1; t <= 4; t++) begin
      ld_issue = 1'b1; ld_issue_rc = 5'(t);
      tick;
    end
    ld_issue = 1'b0;
    #1 chk("full_issue_ready", ld_issue_ready, 0);
    rd_addr2 = 5'd1;
    #1 chk("full_rd2_hazard", hazard, 1);
    rd_addr2 = '0;
    ld_issue = 1'b1; ld_issue_rc = 5'd5; ld_valid = 1'b1; ld_data = 32'hA1;
    expectWr(5'd1, 32'hA1);
    tick;
    ld_issue = 1'b0; ld_valid = 1'b0; rd_addr1 = 5'd5;
    #1 chk("pushpop_full_hazard5", hazard, 1);
    chk("pushpop_still_full", ld_issue_ready, 0);
    rd_addr1 = 5'd1;
`ifdef WB_BYPASS_EN
    #1 chk("popped_tag_hazard", hazard, 0);
`else
    #1 chk("popped_tag_hazard", hazard, 1);
`endif
    ld_issue = 1'b1; ld_issue_rc = 5'd6;
    tick;
    ld_issue = 1'b0; rd_addr1 = 5'd6;
    #1 chk("full_push_ignored", hazard, 0);
    for (int t = 2; t <= 5; t++) begin
      ld_valid = 1'b1; ld_data = 32'hA0 + 32'(t);
      expectWr(5'(t), 32'hA0 + 32'(t));
      tick;
    end
    ld_valid = 1'b0; rd_addr1 = '0;
    #1 chk("drained_issue_ready", ld_issue_ready, 1);

    // Load return with empty FIFO: sticky error, no write, same-cycle push still lands.
    ld_valid = 1'b1; ld_data = 32'hBAD; ld_issue = 1'b1; ld_issue_rc = 5'd12;
    tick;
    ld_valid = 1'b0; ld_issue = 1'b0; rd_addr1 = 5'd12;
    #1 chk("empty_ld_err", ld_err, 1);
    chk("empty_ld_no_write", WriteEnable, 0);
    chk("empty_ld_push_hazard", hazard, 1);
    rd_addr1 = '0;
    ld_valid = 1'b1; ld_data = 32'hC0;
    expectWr(5'd12, 32'hC0);
    tick;
    ld_valid = 1'b0;
    tick;
    chk("ld_err_sticky", ld_err, 1);

    // R31 results are consumed without a write.
    alu_valid = 1'b1; alu_rc = 5'd31; alu_data = 32'h55;
    #1 chk("r31_alu_ready", alu_ready, 1);
    tick;
    alu_valid = 1'b0;
    #1 chk("r31_alu_no_write", WriteEnable, 0);
    ld_issue = 1'b1; ld_issue_rc = 5'd31;
    tick;
    ld_issue = 1'b0; rd_addr1 = 5'd31;
    #1 chk("r31_no_hazard", hazard, 0);
    rd_addr1 = '0;
    ld_valid = 1'b1; ld_data = 32'h77;
    tick;
    ld_valid = 1'b0;
    #1 chk("r31_ld_no_write", WriteEnable, 0);
    ld_issue = 1'b1; ld_issue_rc = 5'd13;
    tick;
    ld_issue = 1'b0; ld_valid = 1'b1; ld_data = 32'hD0;
    expectWr(5'd13, 32'hD0);
    tick;
    ld_valid = 1'b0;

    // Reset with three loads outstanding discards their tags.
    for (int t = 8; t <= 10; t++) begin
      ld_issue = 1'b1; ld_issue_rc = 5'(t);
      tick;
    end
    ld_issue = 1'b0; rd_addr1 = 5'd9;
    #1 chk("pre_reset_hazard", hazard, 1);
    rd_addr1 = '0;
    alu_valid = 1'b1; alu_rc = 5'd20; alu_data = 32'h2020;
    expectWr(5'd20, 32'h2020);
    tick;
    alu_valid = 1'b0; rd_addr2 = 5'd20;
`ifdef WB_BYPASS_EN
    #1 chk("rd2_wb_hazard", hazard, 0);
    chk("fwd_hit2_set", fwd_hit2, 1);
    chk("fwd_hit1_clr", fwd_hit1, 0);
    chk("fwd_data_20", fwd_data, 32'h2020);
`else
    #1 chk("rd2_wb_hazard", hazard, 1);
`endif
    reset = 1'b1; ld_issue = 1'b1; ld_issue_rc = 5'd9; ld_valid = 1'b1;
    tick;
    reset = 1'b0; ld_issue = 1'b0; ld_valid = 1'b0;
    rd_addr1 = 5'd9; rd_addr2 = '0;
    #1 chk("post_rst_hazard", hazard, 0);
    chk("post_rst_issue_ready", ld_issue_ready, 1);
    chk("post_rst_lderr", ld_err, 0);
    chk("post_rst_we", WriteEnable, 0);
    chk("post_rst_waddr", WriteAddr, 0);
    chk("post_rst_wdata", WriteData, 0);
    ld_valid = 1'b1; ld_data = 32'hEE;
    tick;
    ld_valid = 1'b0;
    #1 chk("discarded_tag_lderr", ld_err, 1);
    chk("discarded_tag_no_write", WriteEnable, 0);

    repeat (3) tick;
    chk("exp_queue_empty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL be clocked by a single clock and use a synchronous, active-high reset; both ports are listed first below.
REQ-002 Parameter LD_DEPTH, default 4, SHALL set the number of outstanding load tags (power of two, 2..16).
REQ-003 Ports SHALL be exactly:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present
- alu_ready  out  1  ALU result accepted this cycle
- alu_rc  in  5  ALU destination register
- alu_data  in  32  ALU result
- ld_issue  in  1  load issued to memory; push destination tag
- ld_issue_rc  in  5  load destination register
- ld_issue_ready  out  1  tag FIFO not full
- ld_valid  in  1  load data returning, in issue order
- ld_data  in  32  returned load data
- rd_addr1  in  5  operand-fetch read address 1
- rd_addr2  in  5  operand-fetch read address 2
- hazard  out  1  operand-fetch must stall
- ld_err  out  1  sticky: load returned with no tag pending
- WriteEnable  out  1  register-file write enable
- WriteAddr  out  5  register-file write address
- WriteData  out  32  register-file write data

Function
REQ-004 Load return SHALL have priority: alu_ready = !ld_valid, combinational.
REQ-005 An accepted result (ld_valid, or alu_valid && alu_ready) SHALL drive WriteEnable/WriteAddr/WriteData from registers one cycle later; with no accepted result, WriteEnable SHALL be 0 next cycle and WriteAddr/WriteData SHALL hold.
REQ-006 A load write SHALL use the tag at the FIFO head as WriteAddr and pop it in the same cycle.
REQ-007 Any result destined for R31 SHALL be accepted and consumed, but SHALL produce WriteEnable=0.
REQ-008 ld_issue_ready SHALL be 1 when fewer than LD_DEPTH tags are pending; ld_issue while full SHALL be ignored, with no push and count unchanged.
REQ-009 Simultaneous push and pop SHALL be legal at any occupancy, including full; the count SHALL be unchanged.
REQ-010 ld_valid with an empty FIFO SHALL set ld_err (held until reset), produce no write and no pop; a same-cycle push SHALL still occur.
REQ-011 hazard SHALL be 1 when rd_addr1 or rd_addr2 (not R31) matches any pending tag, compared across all valid FIFO entries.
REQ-012 Pointers SHALL wrap modulo LD_DEPTH; occupancy SHALL be tracked with a count of log2(LD_DEPTH)+1 bits.

Reset
REQ-013 While reset=1, the block SHALL clear the FIFO (count 0, pointers 0), set WriteEnable=0, WriteAddr=0, WriteData=0 and ld_err=0, and ignore all other inputs; hazard SHALL read 0 on the next cycle.
REQ-014 Reset asserted with loads outstanding SHALL discard their tags; later ld_valid SHALL set ld_err.

Configuration
REQ-015 With WB_BYPASS_EN defined, outputs fwd_hit1/fwd_hit2 (1 bit) and fwd_data (32 bit) SHALL be present:
- fwd_hitN = WriteEnable && WriteAddr==rd_addrN
- fwd_data = WriteData
REQ-016 Without WB_BYPASS_EN, hazard SHALL additionally assert when WriteEnable && WriteAddr matches rd_addr1 or rd_addr2, and the forwarding ports SHALL be absent.

Structure
REQ-017 Package wb_pkg SHALL hold REG_ZERO=5'd31, REG_AW=5, DATA_W=32 and the writeback-source enum {WB_NONE, WB_ALU, WB_LD}.
REQ-018 The tag FIFO with parallel match outputs SHALL be sub-module wb_tag_fifo; wb_stage SHALL hold arbitration, the output register and the hazard/bypass logic.

Verification
REQ-019 alu_valid=1, alu_rc=3, alu_data=0xDEADBEEF -> next cycle WriteEnable=1, WriteAddr=3, WriteData=0xDEADBEEF.
REQ-020 ld_valid=1 (tag 7 pending) with alu_valid=1 in the same cycle -> alu_ready=0, write of R7, ALU result written the following cycle.
REQ-021 Issue tags 1,2,3,4 (LD_DEPTH=4) -> ld_issue_ready=0; a 5th ld_issue with ld_valid pops 1 and pushes 5; rd_addr1=5 -> hazard=1.
REQ-022 ld_valid with empty FIFO -> ld_err=1, WriteEnable=0; ld_err holds until reset.
REQ-023 alu_rc=31 -> alu_ready=1, WriteEnable=0.
REQ-024 Reset with 3 tags pending -> hazard=0 and ld_issue_ready=1 after reset; rd_addr=WriteAddr case checked in both WB_BYPASS_EN builds.
